sync_ram_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port sync_ram_memory of the RISC-V core.

---
 rtl/sync_ram_arbiter_if.sv | 40 ++++
 rtl/sync_ram_arbiter.sv | 150 +++++++++++++++
 tb/tb_sync_ram_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_ram_arbiter_if.sv
// Request/acknowledge and RAM-control signals shared between the two CPU
// ports, the arbiter and the single-port RAM.
interface sync_ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  i_req_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic [DATA_WIDTH-1:0] i_rdata_o;
    logic                  i_ack_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_ack_o;

    logic                  ram_cs_o;
    logic                  ram_we_o;
    logic                  ram_oe_o;
    logic [ADDR_WIDTH-1:0] ram_address_o;
    logic                  busy_o;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_rdata_o, i_ack_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_rdata_o, d_ack_o,
        output ram_cs_o, ram_we_o, ram_oe_o, ram_address_o, busy_o
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_rdata_o, i_ack_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_rdata_o, d_ack_o,
        input  ram_cs_o, ram_we_o, ram_oe_o, ram_address_o, busy_o
    );
endinterface

// File: rtl/sync_ram_arbiter.sv
// Round-robin sequencer sharing one synchronous single-port RAM between the
// instruction-fetch port and the load/store port, one transaction at a time.
module sync_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_clk_i,
    input  logic                  rst_n_i,
    sync_ram_arbiter_if.slave     bus,
    inout  wire  [DATA_WIDTH-1:0] ram_data_io
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    state_t                state_q, state_d;
    logic                  port_q, port_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic                  oe_q, oe_d;
    logic                  i_ack_q, i_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  busy_q, busy_d;
    logic                  grant_data;

    // RAM strobes are computed for the state being entered, so every output is a flop.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        oe_d         = 1'b0;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        grant_data   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_req_i || bus.d_req_i) begin
                    // On a tie the port that was not served last time wins.
                    grant_data   = bus.d_req_i &&
                                   (!bus.i_req_i || (last_grant_q == PORT_FETCH));
                    port_d       = grant_data;
                    last_grant_d = grant_data;
                    addr_d       = grant_data ? bus.d_addr_i : bus.i_addr_i;
                    wdata_d      = bus.d_wdata_i;
                    cs_d         = 1'b1;
                    if (grant_data && bus.d_we_i) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                    end else begin
                        state_d = RD_ADDR;
                        oe_d    = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                state_d = RD_DATA;
                cs_d    = 1'b1;
                oe_d    = 1'b1;
            end
            RD_DATA: begin
                state_d = DONE;
                if (port_q == PORT_DATA) begin
                    d_rdata_d = ram_data_io;
                    d_ack_d   = 1'b1;
                end else begin
                    i_rdata_d = ram_data_io;
                    i_ack_d   = 1'b1;
                end
            end
            WRITE: begin
                state_d = DONE;
                d_ack_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            port_q       <= PORT_FETCH;
            last_grant_q <= PORT_DATA;
            addr_q       <= '0;
            wdata_q      <= '0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            oe_q         <= oe_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // we_q is high only in WRITE, so the RAM and the arbiter never drive together.
    assign ram_data_io = we_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign bus.ram_cs_o      = cs_q;
    assign bus.ram_we_o      = we_q;
    assign bus.ram_oe_o      = oe_q;
    assign bus.ram_address_o = addr_q;
    assign bus.i_ack_o       = i_ack_q;
    assign bus.d_ack_o       = d_ack_q;
    assign bus.i_rdata_o     = i_rdata_q;
    assign bus.d_rdata_o     = d_rdata_q;
    assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Bench for sync_ram_arbiter: synchronous RAM model on the shared bus, directed
// scenarios, then randomized traffic checked against a round-robin reference model.
module tb_sync_ram_arbiter;

    localparam logic FETCH = 1'b0;
    localparam logic DATA  = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    sync_ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
    wire [31:0] ram_data;

    sync_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk_clk_i   (clk),
        .rst_n_i     (rst_n),
        .bus         (bus),
        .ram_data_io (ram_data)
    );

    always #5 clk = ~clk;

    // Reference state: expected memory contents, last winner, held read data.
    logic [31:0] ref_mem [256];
    logic        model_last;
    logic [31:0] exp_i_rd;
    logic [31:0] exp_d_rd;

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
    endfunction

    // Synchronous RAM: word registered on a read edge, driven while cs&oe&!we.
    logic [31:0] ram_mem [256];
    logic [31:0] ram_rd = 32'h0;
    logic        ram_loaded = 1'b0;

    assign ram_data = (bus.ram_cs_o && bus.ram_oe_o && !bus.ram_we_o) ? ram_rd : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (bus.ram_cs_o) begin
            if (bus.ram_we_o) ram_mem[bus.ram_address_o] <= ram_data;
            else if (bus.ram_oe_o) ram_rd <= ram_mem[bus.ram_address_o];
        end
    end

    // Every-cycle protocol monitor.
    always @(negedge clk) begin
        total++;
        if (bus.ram_we_o && bus.ram_oe_o) begin
            bad++;
            $display("[TB] FAIL mon_we_oe: we=%b oe=%b, required not both high", bus.ram_we_o, bus.ram_oe_o);
        end
        total++;
        if (bus.i_ack_o && bus.d_ack_o) begin
            bad++;
            $display("[TB] FAIL mon_one_ack: i_ack=%b d_ack=%b, required at most one", bus.i_ack_o, bus.d_ack_o);
        end
        if (bus.ram_we_o) begin
            total++;
            if ({bus.ram_cs_o, bus.ram_address_o, ram_data} !== {1'b1, bus.d_addr_i, bus.d_wdata_i}) begin
                bad++;
                $display("[TB] FAIL mon_write_bus: cs=%b addr=%h data=%h, required cs=1 addr=%h data=%h",
                         bus.ram_cs_o, bus.ram_address_o, ram_data, bus.d_addr_i, bus.d_wdata_i);
            end
        end
    end

    // Drives one single-port transaction from an idle negedge; lat = ack cycle or -1.
    task automatic drive_single(input logic is_data, input logic we, input logic [7:0] addr,
                                input logic [31:0] wdata, output int lat);
        lat = -1;
        if (is_data) begin
            bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_addr_i = addr; bus.d_wdata_i = wdata;
        end else begin
            bus.i_req_i = 1'b1; bus.i_addr_i = addr;
        end
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if ((is_data && bus.d_ack_o) || (!is_data && bus.i_ack_o)) begin
                lat = n;
                break;
            end
        end
        bus.i_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req_i = 1'b0; bus.i_addr_i = 8'h0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = 8'h0; bus.d_wdata_i = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.ram_cs_o, bus.ram_we_o, bus.ram_oe_o, bus.ram_address_o, bus.i_ack_o, bus.d_ack_o, bus.busy_o} !== 14'h0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: cs=%b we=%b oe=%b addr=%h acks=%b%b busy=%b, required all 0",
                     bus.ram_cs_o, bus.ram_we_o, bus.ram_oe_o, bus.ram_address_o, bus.i_ack_o, bus.d_ack_o, bus.busy_o);
        end
        total++;
        if ({bus.i_rdata_o, bus.d_rdata_o} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_rdata: i=%h d=%h, required 0", bus.i_rdata_o, bus.d_rdata_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.busy_o, bus.ram_cs_o} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_idle: busy=%b cs=%b, required 00", bus.busy_o, bus.ram_cs_o);
        end
        model_last = DATA;
        exp_i_rd = 32'h0;
        exp_d_rd = 32'h0;
    endtask

    task automatic test_store();
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 8'h05; bus.d_wdata_i = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if ({bus.ram_cs_o, bus.ram_we_o, bus.ram_oe_o, bus.d_ack_o, bus.busy_o, bus.ram_address_o, ram_data}
            !== {5'b11001, 8'h05, 32'hDEADBEEF}) begin
            bad++;
            $display("[TB] FAIL store_write: cs=%b we=%b oe=%b ack=%b busy=%b addr=%h bus=%h, required 1 1 0 0 1 05 deadbeef",
                     bus.ram_cs_o, bus.ram_we_o, bus.ram_oe_o, bus.d_ack_o, bus.busy_o, bus.ram_address_o, ram_data);
        end
        @(negedge clk);
        total++;
        if ({bus.d_ack_o, bus.i_ack_o, bus.ram_cs_o, bus.ram_we_o} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL store_ack: d_ack=%b i_ack=%b cs=%b we=%b, required 1000",
                     bus.d_ack_o, bus.i_ack_o, bus.ram_cs_o, bus.ram_we_o);
        end
        bus.d_req_i = 1'b0;
        ref_mem[5] = 32'hDEADBEEF;
        model_last = DATA;
        @(negedge clk);
    endtask

    task automatic test_load();
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 8'h05;
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            total++;
            if ({bus.ram_cs_o, bus.ram_oe_o, bus.ram_we_o, bus.d_ack_o, bus.ram_address_o} !== {4'b1100, 8'h05}) begin
                bad++;
                $display("[TB] FAIL load_strobe%0d: cs=%b oe=%b we=%b ack=%b addr=%h, required 1 1 0 0 05",
                         n, bus.ram_cs_o, bus.ram_oe_o, bus.ram_we_o, bus.d_ack_o, bus.ram_address_o);
            end
        end
        @(negedge clk);
        exp_d_rd = ref_mem[5];
        total++;
        if ({bus.d_ack_o, bus.ram_cs_o, bus.d_rdata_o} !== {2'b10, exp_d_rd}) begin
            bad++;
            $display("[TB] FAIL load_ack: ack=%b cs=%b rdata=%h, required 1 0 %h",
                     bus.d_ack_o, bus.ram_cs_o, bus.d_rdata_o, exp_d_rd);
        end
        bus.d_req_i = 1'b0;
        model_last = DATA;
        @(negedge clk);
        total++;
        if ({bus.d_ack_o, bus.busy_o, bus.d_rdata_o} !== {2'b00, exp_d_rd}) begin
            bad++;
            $display("[TB] FAIL load_after: ack=%b busy=%b rdata=%h, required 0 0 %h",
                     bus.d_ack_o, bus.busy_o, bus.d_rdata_o, exp_d_rd);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] ia;
        logic [7:0] da;
        int         served;
        test_reset();
        ia = 8'($urandom_range(16, 31));
        da = 8'($urandom_range(32, 47));
        bus.i_req_i = 1'b1; bus.i_addr_i = ia;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = da;
        served = 0;
        // Both held: winners alternate F,D,F,D with a 4-cycle read period.
        for (int n = 1; n <= 16; n++) begin
            logic exp_i;
            logic exp_d;
            @(negedge clk);
            exp_i = 1'b0;
            exp_d = 1'b0;
            if (n % 4 == 3) begin
                if (model_last == DATA) begin exp_i = 1'b1; exp_i_rd = ref_mem[ia]; model_last = FETCH; end
                else begin exp_d = 1'b1; exp_d_rd = ref_mem[da]; model_last = DATA; end
                served++;
            end
            total++;
            if ({bus.i_ack_o, bus.d_ack_o} !== {exp_i, exp_d}) begin
                bad++;
                $display("[TB] FAIL rr_ack n=%0d: i_ack=%b d_ack=%b, required %b %b", n, bus.i_ack_o, bus.d_ack_o, exp_i, exp_d);
            end
            if (exp_i || exp_d) begin
                total++;
                if ({bus.i_rdata_o, bus.d_rdata_o} !== {exp_i_rd, exp_d_rd}) begin
                    bad++;
                    $display("[TB] FAIL rr_rdata n=%0d: i=%h d=%h, required %h %h", n, bus.i_rdata_o, bus.d_rdata_o, exp_i_rd, exp_d_rd);
                end
            end
            if (served == 4) begin
                bus.i_req_i = 1'b0;
                bus.d_req_i = 1'b0;
            end
        end
    endtask

    task automatic test_fetch_stream();
        int         lat;
        int         last_ack;
        int         k;
        logic [31:0] w;
        for (int a = 0; a < 4; a++) begin
            w = $urandom();
            drive_single(DATA, 1'b1, 8'(a), w, lat);
            ref_mem[a] = w;
            model_last = DATA;
            total++;
            if (lat !== 2) begin
                bad++;
                $display("[TB] FAIL stream_store%0d: latency=%0d, required 2", a, lat);
            end
        end
        bus.i_req_i = 1'b1; bus.i_addr_i = 8'h00;
        k = 0;
        last_ack = 0;
        for (int n = 1; n <= 40 && k < 4; n++) begin
            @(negedge clk);
            if (bus.i_ack_o) begin
                exp_i_rd = ref_mem[k];
                model_last = FETCH;
                total++;
                if ({bus.i_rdata_o, bus.d_rdata_o} !== {exp_i_rd, exp_d_rd}) begin
                    bad++;
                    $display("[TB] FAIL stream_data%0d: i=%h d=%h, required %h %h", k, bus.i_rdata_o, bus.d_rdata_o, exp_i_rd, exp_d_rd);
                end
                total++;
                if (n - last_ack !== ((k == 0) ? 3 : 4)) begin
                    bad++;
                    $display("[TB] FAIL stream_gap%0d: gap=%0d, required %0d", k, n - last_ack, (k == 0) ? 3 : 4);
                end
                last_ack = n;
                k++;
                bus.i_addr_i = 8'(k);
                if (k == 4) bus.i_req_i = 1'b0;
            end
        end
        total++;
        if (k !== 4) begin
            bad++;
            $display("[TB] FAIL stream_count: acks=%0d, required 4", k);
        end
        bus.i_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 8'h07;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.ram_cs_o, bus.ram_we_o, bus.ram_oe_o, bus.ram_address_o, bus.i_ack_o, bus.d_ack_o, bus.busy_o} !== 14'h0) begin
            bad++;
            $display("[TB] FAIL midreset_ctrl: cs=%b we=%b oe=%b addr=%h acks=%b%b busy=%b, required all 0",
                     bus.ram_cs_o, bus.ram_we_o, bus.ram_oe_o, bus.ram_address_o, bus.i_ack_o, bus.d_ack_o, bus.busy_o);
        end
        total++;
        if ({bus.i_rdata_o, bus.d_rdata_o} !== 64'h0) begin
            bad++;
            $display("[TB] FAIL midreset_rdata: i=%h d=%h, required 0", bus.i_rdata_o, bus.d_rdata_o);
        end
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({bus.i_ack_o, bus.d_ack_o} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL midreset_noack: acks=%b%b, required 00", bus.i_ack_o, bus.d_ack_o);
            end
        end
        bus.d_req_i = 1'b0;
        rst_n = 1'b1;
        model_last = DATA;
        exp_i_rd = 32'h0;
        exp_d_rd = 32'h0;
        @(negedge clk);
        drive_single(DATA, 1'b0, 8'h07, 32'h0, lat);
        exp_d_rd = ref_mem[7];
        total++;
        if (lat !== 3 || bus.d_rdata_o !== exp_d_rd) begin
            bad++;
            $display("[TB] FAIL midreset_fresh: latency=%0d rdata=%h, required 3 %h", lat, bus.d_rdata_o, exp_d_rd);
        end
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            int          mode;
            logic        use_i, use_d, dwe, data_first;
            logic [7:0]  ia, da;
            logic [31:0] dw, new_i, new_d;
            int          lat_i, lat_d, t_i, t_d, tmax;
            mode  = int'($urandom_range(0, 2));
            use_i = (mode != 1);
            use_d = (mode != 0);
            ia    = 8'($urandom_range(0, 15));
            da    = 8'($urandom_range(0, 15));
            dwe   = 1'($urandom_range(0, 1));
            dw    = $urandom();
            lat_i = 3;
            lat_d = dwe ? 2 : 3;
            data_first = (use_i && use_d) ? (model_last == FETCH) : use_d;
            t_i = 0;
            t_d = 0;
            new_i = exp_i_rd;
            new_d = exp_d_rd;
            // Serve in predicted order so a same-address read sees the earlier write.
            if (data_first) begin
                t_d = lat_d;
                if (dwe) ref_mem[da] = dw; else new_d = ref_mem[da];
                if (use_i) begin t_i = lat_d + 1 + lat_i; new_i = ref_mem[ia]; end
            end else begin
                t_i = lat_i;
                new_i = ref_mem[ia];
                if (use_d) begin
                    t_d = lat_i + 1 + lat_d;
                    if (dwe) ref_mem[da] = dw; else new_d = ref_mem[da];
                end
            end
            model_last = (use_i && use_d) ? !data_first : data_first;
            tmax = (t_i > t_d) ? t_i : t_d;

            bus.i_req_i = use_i; bus.i_addr_i = ia;
            bus.d_req_i = use_d; bus.d_we_i = dwe; bus.d_addr_i = da; bus.d_wdata_i = dw;
            for (int n = 1; n <= tmax + 1; n++) begin
                @(negedge clk);
                total++;
                if ({bus.i_ack_o, bus.d_ack_o} !== {n == t_i, n == t_d}) begin
                    bad++;
                    $display("[TB] FAIL rand_ack r=%0d n=%0d: acks=%b%b, required %b%b",
                             r, n, bus.i_ack_o, bus.d_ack_o, n == t_i, n == t_d);
                end
                if (n == t_i) begin exp_i_rd = new_i; bus.i_req_i = 1'b0; end
                if (n == t_d) begin exp_d_rd = new_d; bus.d_req_i = 1'b0; end
                if (n == t_i || n == t_d) begin
                    total++;
                    if ({bus.i_rdata_o, bus.d_rdata_o} !== {exp_i_rd, exp_d_rd}) begin
                        bad++;
                        $display("[TB] FAIL rand_rdata r=%0d n=%0d: i=%h d=%h, required %h %h",
                                 r, n, bus.i_rdata_o, bus.d_rdata_o, exp_i_rd, exp_d_rd);
                    end
                end
            end
            bus.i_req_i = 1'b0;
            bus.d_req_i = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_store();
        test_load();
        test_round_robin();
        test_fetch_stream();
        test_reset_mid();
        test_random(40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
